fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning the data word width; it SHALL match the DSIZE of the async_fifo1 instance it drains.
REQ-002 The block SHALL have parameter CWIDTH, default 16, meaning the width of the transfer counter.
REQ-003 The block SHALL have port rclk, input, 1 bit: the single clock, which is the read-domain clock of the FIFO.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port rempty, input, 1 bit: FIFO empty flag, registered in rclk.
REQ-006 The block SHALL have port rdata, input, DSIZE bits: FIFO head word, show-ahead, valid whenever rempty=0.
REQ-007 The block SHALL have port rinc, output, 1 bit: FIFO pop request.
REQ-008 The block SHALL have port m_data, output, DSIZE bits: stream data.
REQ-009 The block SHALL have port m_valid, output, 1 bit: stream valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: stream ready.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous discard of buffered words.
REQ-012 The block SHALL have port xfer_count, output, CWIDTH bits: number of completed stream transfers.

Function
REQ-013 The block SHALL hold a 2-entry FIFO-ordered skid buffer with occupancy occ in 0..2; m_valid SHALL be (occ!=0) and m_data SHALL be the oldest entry, both driven from registers.
REQ-014 rinc SHALL be asserted as (!rempty && !flush && occ<2), with no combinational path from m_ready.
REQ-015 Push SHALL be rinc; the word captured SHALL be rdata sampled at the same rclk edge.
REQ-016 Pop SHALL be (m_valid && m_ready); a push and a pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-017 Latency from rempty=0 with occ=0 to m_valid=1 SHALL be exactly 1 cycle.
REQ-018 With rempty=0 and m_ready=1 held, throughput SHALL be 1 word per cycle (occ steady at 1).
REQ-019 With m_ready=0, the block SHALL fill to occ=2, then deassert rinc; m_data and m_valid SHALL be held stable until a pop occurs.
REQ-020 A pop when occ=2 SHALL present the second entry on the next cycle with no bubble.
REQ-021 flush=1 SHALL force occ to 0 at the next edge, even if a pop occurs in the same cycle. No push SHALL occur in that cycle.
REQ-022 xfer_count SHALL increment by 1 on each pop, including a pop in a flush cycle, and SHALL wrap from 2^CWIDTH-1 to 0.
REQ-023 rinc SHALL never be asserted while rempty=1.

Reset
REQ-024 When rrst_n=0, the block SHALL asynchronously set occ=0, m_valid=0, m_data=0, xfer_count=0 and rinc=0.
REQ-025 A word popped from the FIFO but not yet transferred when reset asserts SHALL be lost; after release, operation SHALL resume on the first edge with rrst_n=1.
REQ-026 Reset mid-stream SHALL NOT produce a spurious m_valid pulse.

Structure
REQ-027 The shared package SHALL hold the default widths (DSIZE, CWIDTH) and the occupancy type (2-bit).
REQ-028 The block SHALL be one module with no sub-module; the 2-entry buffer SHALL be inline registers (head and tail) plus occ.
REQ-029 The block SHALL be instantiated beside async_fifo1 on the rclk side, connected rinc to rinc, rempty to rempty and rdata to rdata.

Verification
REQ-030 Reset, then FIFO preloaded with 0x11,0x22,0x33 and m_ready=1 -> m_valid is high on 3 consecutive cycles with data 0x11,0x22,0x33 starting 1 cycle after rempty falls; xfer_count=3.
REQ-031 Words 0xA0..0xA4 with m_ready=0 -> occ=2, rinc low after 2 pops, m_data=0xA0 stable; then m_ready=1 -> 0xA0..0xA4 in order with no gaps.
REQ-032 m_ready toggled 1,0,1,0 with continuous input 0x00..0x0F -> all 16 words in order, none duplicated or lost; rinc never high while rempty=1.
REQ-033 occ=2 (0x55,0x66) with flush=1 for 1 cycle and m_ready=1 -> next cycle m_valid=0, xfer_count +1 (0x55 transferred), 0x66 discarded, no FIFO pop in the flush cycle.
REQ-034 xfer_count preset by 65535 transfers, then one more transfer -> xfer_count=0.
REQ-035 rrst_n pulsed low mid-stream at occ=1 -> m_valid=0 and xfer_count=0 immediately (asynchronously); the stream resumes with the next FIFO word after release.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared widths and occupancy encoding for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

   localparam int DSIZE_DEF  = 8;
   localparam int CWIDTH_DEF = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains an async FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// rinc depends only on rempty, flush and registered occupancy, never on m_ready.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DSIZE  = DSIZE_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              rempty,
   input  logic [DSIZE-1:0]  rdata,
   output logic              rinc,
   output logic [DSIZE-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic              flush,
   output logic [CWIDTH-1:0] xfer_count
);

   occ_t              occ_q, occ_d;
   logic [DSIZE-1:0]  head_q, head_d;
   logic [DSIZE-1:0]  tail_q, tail_d;
   logic              valid_q, valid_d;
   logic [CWIDTH-1:0] cnt_q, cnt_d;
   logic              push, pop;

   always_comb begin
      rinc    = rrst_n & ~rempty & ~flush & (occ_q != OCC_FULL);
      push    = rinc;
      pop     = valid_q & m_ready;
      occ_d   = occ_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q + CWIDTH'(pop);
      if (flush) begin
         // Buffered words are dropped; a pop in this cycle still counts.
         occ_d = OCC_EMPTY;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_q == OCC_EMPTY) begin
                  head_d = rdata;
                  occ_d  = OCC_ONE;
               end else begin
                  tail_d = rdata;
                  occ_d  = OCC_FULL;
               end
            end
            2'b01: begin
               if (occ_q == OCC_FULL) head_d = tail_q;
               occ_d = occ_q - OCC_ONE;
            end
            // Push with pop only happens at occ=1, so the new word becomes head.
            2'b11: head_d = rdata;
            default: ;
         endcase
      end
      valid_d = (occ_d != OCC_EMPTY);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         occ_q   <= OCC_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_data     = head_q;
   assign m_valid    = valid_q;
   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural show-ahead FIFO source feeding fifo_stream_reader.
module tb_fifo_stream_reader;

   logic        rclk;
   logic        rrst_n;
   logic        rempty;
   logic [7:0]  rdata;
   logic        rinc;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        flush;
   logic [15:0] xfer_count;

   logic [7:0]  mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic [15:0] inf_cnt = '0;
   logic        src_inf = 1'b0;
   logic        capture = 1'b0;
   int          viol = 0;
   logic [7:0]  got [$];

   int tests = 0;
   int fails = 0;
   int base;

   fifo_stream_reader #(.DSIZE(8), .CWIDTH(16)) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .flush      (flush),
      .xfer_count (xfer_count)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   assign rempty = src_inf ? 1'b0 : (rd_ptr == wr_ptr);
   assign rdata  = src_inf ? inf_cnt[7:0] : mem[rd_ptr[5:0]];

   always @(posedge rclk) begin
      if (rinc) begin
         if (src_inf) inf_cnt <= inf_cnt + 16'd1;
         else         rd_ptr  <= rd_ptr + 1;
      end
   end

   always @(posedge rclk) begin
      if (rinc && rempty) viol <= viol + 1;
      if (capture && rrst_n && m_valid && m_ready) got.push_back(m_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
   endtask

   initial begin
      rrst_n  = 1'b0;
      m_ready = 1'b0;
      flush   = 1'b0;
      put(8'h11); put(8'h22); put(8'h33);
      repeat (3) @(negedge rclk);
      check("rst_valid", m_valid, 0);
      check("rst_data",  m_data, 0);
      check("rst_count", xfer_count, 0);
      check("rst_rinc",  rinc, 0);

      // Preloaded 0x11,0x22,0x33 streamed at full rate
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      #1 check("t1_pre_valid", m_valid, 0);
      @(negedge rclk); check("t1_v0", m_valid, 1); check("t1_d0", m_data, 8'h11);
      @(negedge rclk); check("t1_v1", m_valid, 1); check("t1_d1", m_data, 8'h22);
      @(negedge rclk); check("t1_v2", m_valid, 1); check("t1_d2", m_data, 8'h33);
      @(negedge rclk); check("t1_end_valid", m_valid, 0); check("t1_count", xfer_count, 3);

      // One-cycle latency from rempty falling with empty buffer
      put(8'h44);
      #1 check("lat_rinc", rinc, 1); check("lat_valid_before", m_valid, 0);
      @(negedge rclk); check("lat_valid", m_valid, 1); check("lat_data", m_data, 8'h44);
      @(negedge rclk); check("lat_drain", m_valid, 0); check("lat_count", xfer_count, 4);

      // Backpressure: fill to two, hold, then release
      m_ready = 1'b0;
      base = rd_ptr;
      for (int k = 0; k < 5; k++) put(8'hA0 + 8'(k));
      repeat (2) @(negedge rclk);
      check("bp_rinc_low", rinc, 0);
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 8'hA0);
      check("bp_pops", rd_ptr - base, 2);
      @(negedge rclk);
      check("bp_hold_data", m_data, 8'hA0);
      check("bp_hold_pops", rd_ptr - base, 2);
      m_ready = 1'b1;
      #1 check("bp_rel_v0", m_valid, 1);
      for (int k = 1; k < 5; k++) begin
         @(negedge rclk);
         check("bp_rel_valid", m_valid, 1);
         check("bp_rel_data", m_data, 32'hA0 + 32'(k));
      end
      @(negedge rclk); check("bp_end_valid", m_valid, 0); check("bp_count", xfer_count, 9);

      // Toggling ready with 16 words queued
      capture = 1'b1;
      for (int k = 0; k < 16; k++) put(8'(k));
      for (int c = 0; c < 200 && got.size() < 16; c++) begin
         m_ready = (c % 2 == 0);
         @(negedge rclk);
      end
      capture = 1'b0;
      m_ready = 1'b1;
      check("tog_size", got.size(), 16);
      for (int k = 0; k < 16; k++)
         if (k < got.size()) check("tog_word", got[k], k);
      @(negedge rclk);
      check("tog_count", xfer_count, 25);

      // Flush at occupancy two with a pop in the same cycle
      m_ready = 1'b0;
      base = rd_ptr;
      put(8'h55); put(8'h66); put(8'h77);
      repeat (2) @(negedge rclk);
      check("fl_pre_data", m_data, 8'h55);
      check("fl_pre_rinc", rinc, 0);
      flush = 1'b1; m_ready = 1'b1;
      #1 check("fl_rinc", rinc, 0);
      @(negedge rclk);
      check("fl_valid", m_valid, 0);
      check("fl_count", xfer_count, 26);
      check("fl_pops", rd_ptr - base, 2);
      check("fl_hold_rinc", rinc, 0);
      @(negedge rclk);
      check("fl_hold_pops", rd_ptr - base, 2);
      check("fl_hold_valid", m_valid, 0);
      flush = 1'b0;
      @(negedge rclk); check("fl_next_valid", m_valid, 1); check("fl_next_data", m_data, 8'h77);
      @(negedge rclk); check("fl_next_count", xfer_count, 27); check("fl_next_drain", m_valid, 0);

      // Asynchronous reset mid-stream at occupancy one
      m_ready = 1'b0;
      put(8'h81);
      @(negedge rclk); check("ar_pre_valid", m_valid, 1); check("ar_pre_data", m_data, 8'h81);
      put(8'h82); put(8'h83);
      #1 rrst_n = 1'b0;
      #1 check("ar_valid", m_valid, 0);
      check("ar_data", m_data, 0);
      check("ar_count", xfer_count, 0);
      check("ar_rinc", rinc, 0);
      @(negedge rclk); check("ar_no_pulse", m_valid, 0);
      rrst_n = 1'b1; m_ready = 1'b1;
      @(negedge rclk); check("ar_res_valid", m_valid, 1); check("ar_res_d0", m_data, 8'h82);
      @(negedge rclk); check("ar_res_d1", m_data, 8'h83);
      @(negedge rclk); check("ar_res_drain", m_valid, 0); check("ar_res_count", xfer_count, 2);

      // Counter wrap after 65535 transfers
      src_inf = 1'b1;
      for (int c = 0; c < 70000; c++) begin
         if (xfer_count == 16'hFFFF) break;
         @(negedge rclk);
      end
      m_ready = 1'b0;
      check("wrap_reach", xfer_count, 16'hFFFF);
      @(negedge rclk);
      check("wrap_hold", xfer_count, 16'hFFFF);
      check("wrap_valid", m_valid, 1);
      m_ready = 1'b1;
      @(negedge rclk);
      m_ready = 1'b0;
      check("wrap_zero", xfer_count, 0);

      check("rinc_while_empty", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
